riscv_reg_file: RTL and testbench

- Integer register file (x0..x31) for the single-cycle RV32I datapath.
- Two asynchronous read ports, A1/RD1 for rs1 and A2/RD2 for rs2, feed the ALU and store-data path.
- One synchronous write port, A3/WD3/WE3 for rd, is driven by the writeback mux.
- Register x0 is hardwired to zero.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/riscv_reg_read_port.sv | 33 +++
 rtl/riscv_reg_file.sv | 63 ++++++
 tb/tb_riscv_reg_file.sv | 139 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I register file types and constants
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/riscv_reg_read_port.sv
// rtl/riscv_reg_read_port.sv - combinational register read mux with x0 forcing and optional write-through
module riscv_reg_read_port
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int NREGS     = riscv_pkg::NREGS,
  parameter bit WR_BYPASS = 1'b0
) (
  input  logic [$clog2(NREGS)-1:0] addr,
  input  logic [XLEN-1:0]          regs [NREGS],
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  output logic [XLEN-1:0]          rdata
);

  logic bypass_hit;

  // x0 is excluded from bypass so a write attempt to x0 can never leak out
  assign bypass_hit = WR_BYPASS && we && (waddr == addr) && (addr != REG_ZERO);

  always_comb begin
    rdata = '0;
    if (addr == REG_ZERO) begin
      rdata = '0;
    end else if (bypass_hit) begin
      rdata = wdata;
    end else begin
      rdata = regs[addr];
    end
  end

endmodule

// File: rtl/riscv_reg_file.sv
// rtl/riscv_reg_file.sv - RV32I integer register file, two async read ports and one sync write port
module riscv_reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN      = riscv_pkg::XLEN,
  parameter int NREGS     = riscv_pkg::NREGS,
  parameter bit WR_BYPASS = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] A1,
  input  logic [$clog2(NREGS)-1:0] A2,
  input  logic [$clog2(NREGS)-1:0] A3,
  input  logic                     WE3,
  input  logic [XLEN-1:0]          WD3,
  output logic [XLEN-1:0]          RD1,
  output logic [XLEN-1:0]          RD2
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_en;

  assign wr_en = WE3 && (A3 != REG_ZERO);

  // Entry 0 is pinned to zero every cycle; reset wins over a coincident write
  always_ff @(posedge clk) begin
    regs[0] <= '0;
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[A3] <= WD3;
    end
  end

  riscv_reg_read_port #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .WR_BYPASS (WR_BYPASS)
  ) u_rd1 (
    .addr  (A1),
    .regs  (regs),
    .we    (WE3),
    .waddr (A3),
    .wdata (WD3),
    .rdata (RD1)
  );

  riscv_reg_read_port #(
    .XLEN      (XLEN),
    .NREGS     (NREGS),
    .WR_BYPASS (WR_BYPASS)
  ) u_rd2 (
    .addr  (A2),
    .regs  (regs),
    .we    (WE3),
    .waddr (A3),
    .wdata (WD3),
    .rdata (RD2)
  );

endmodule

// File: tb/tb_riscv_reg_file.sv
// tb/tb_riscv_reg_file.sv - directed self-checking bench for riscv_reg_file
module tb_riscv_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [4:0]  A3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] RD1_b;
  logic [31:0] RD2_b;

  int errors;
  int checks;

  riscv_reg_file #(.XLEN(32), .NREGS(32), .WR_BYPASS(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WE3   (WE3),
    .WD3   (WD3),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  riscv_reg_file #(.XLEN(32), .NREGS(32), .WR_BYPASS(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WE3   (WE3),
    .WD3   (WD3),
    .RD1   (RD1_b),
    .RD2   (RD2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    A1     = 5'd0;
    A2     = 5'd0;
    A3     = 5'd0;
    WE3    = 1'b0;
    WD3    = 32'd0;

    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      chk($sformatf("reset_rd1_a%0d", i), RD1, 32'd0);
      chk($sformatf("reset_rd2_a%0d", 31 - i), RD2, 32'd0);
    end

    WE3 = 1'b1; WD3 = 32'd12; A3 = 5'd10; tick();
    WD3 = 32'd15; A3 = 5'd20; tick();
    WD3 = 32'd12; A3 = 5'd30; tick();
    WE3 = 1'b0;
    A1 = 5'd10; A2 = 5'd20; #1;
    chk("write_rd1_x10", RD1, 32'd12);
    chk("write_rd2_x20", RD2, 32'd15);
    chk("write_b_rd1_x10", RD1_b, 32'd12);
    A1 = 5'd30; #1;
    chk("write_rd1_x30", RD1, 32'd12);

    WE3 = 1'b0; WD3 = 32'd15; A3 = 5'd10;
    tick();
    tick();
    A1 = 5'd10; A2 = 5'd20; #1;
    chk("wdis_rd1_x10", RD1, 32'd12);
    chk("wdis_rd2_x20", RD2, 32'd15);

    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hDEADBEEF; A1 = 5'd0; A2 = 5'd0; #1;
    chk("x0_nobypass_b_rd1", RD1_b, 32'd0);
    chk("x0_nobypass_b_rd2", RD2_b, 32'd0);
    tick();
    WE3 = 1'b0; #1;
    chk("x0_rd1", RD1, 32'd0);
    chk("x0_rd2", RD2, 32'd0);
    chk("x0_b_rd1", RD1_b, 32'd0);

    A1 = 5'd10; A2 = 5'd10; WE3 = 1'b1; A3 = 5'd10; WD3 = 32'd99; #1;
    chk("rdw_pre_rd1", RD1, 32'd12);
    chk("rdw_pre_rd2_same_addr", RD2, 32'd12);
    chk("rdw_pre_b_rd1", RD1_b, 32'd99);
    chk("rdw_pre_b_rd2", RD2_b, 32'd99);
    tick();
    WE3 = 1'b0; #1;
    chk("rdw_post_rd1", RD1, 32'd99);
    chk("rdw_post_b_rd1", RD1_b, 32'd99);
    A2 = 5'd20; #1;
    chk("rdw_other_rd2_x20", RD2, 32'd15);

    rst_n = 1'b0; WE3 = 1'b1; A3 = 5'd5; WD3 = 32'd7;
    tick();
    rst_n = 1'b1; WE3 = 1'b0;
    A1 = 5'd5; A2 = 5'd10; #1;
    chk("rstpri_rd1_x5", RD1, 32'd0);
    chk("rstpri_rd2_x10", RD2, 32'd0);
    A1 = 5'd20; A2 = 5'd30; #1;
    chk("rstpri_rd1_x20", RD1, 32'd0);
    chk("rstpri_rd2_x30", RD2, 32'd0);
    chk("rstpri_b_rd2_x30", RD2_b, 32'd0);

    WE3 = 1'b1; A3 = 5'd31; WD3 = 32'hFFFF_FFFF;
    tick();
    WE3 = 1'b0; A1 = 5'd31; A2 = 5'd1; #1;
    chk("post_rst_rd1_x31", RD1, 32'hFFFF_FFFF);
    chk("post_rst_rd2_x1", RD2, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
